// File: rtl/ppu_pkg.sv
// Shared pixel-pipeline definitions: row geometry, the mixed pixel word layout
// and the source encoding used by the mixer and row buffer.
package ppu_pkg;
  localparam int ROW_W      = 320;
  localparam int PIXEL_W    = 10;
  localparam int COL_ADDR_W = 9;

  // SP occupies both 1x codes; SRC_SP_ALT only exists so every code is named.
  typedef enum logic [1:0] {
    SRC_BG     = 2'b00,
    SRC_FG     = 2'b01,
    SRC_SP     = 2'b10,
    SRC_SP_ALT = 2'b11
  } src_e;

  typedef struct packed {
    logic [3:0] color;
    logic [3:0] palette;
    src_e       source;
  } pixel_t;

  localparam pixel_t BACKDROP = '{color: 4'd0, palette: 4'd0, source: SRC_BG};

  function automatic logic col_valid(input logic [COL_ADDR_W-1:0] col);
    return int'(col) < ROW_W;
  endfunction
endpackage

// File: rtl/row_buffer_swap_if.sv
// Writer, reader and video-timing signals of the double-buffered row store.
interface row_buffer_swap_if;
  import ppu_pkg::*;

  logic                  wr_en;
  logic [COL_ADDR_W-1:0] wr_addr;
  logic [PIXEL_W-1:0]    wr_data;
  logic                  wr_done;
  logic [COL_ADDR_W-1:0] rd_addr;
  logic [PIXEL_W-1:0]    rd_data;
  logic                  swap;
  logic                  row_start;
  logic                  late_row;
  logic                  front_sel;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_addr, swap,
    input  rd_data, row_start, late_row, front_sel
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_addr, swap,
    output rd_data, row_start, late_row, front_sel
  );
endinterface

// File: rtl/rowbuf_ram.sv
// One row bank: simple dual-port RAM with a single write port and a registered
// read port. Contents are not reset.
module rowbuf_ram
  import ppu_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [COL_ADDR_W-1:0] waddr,
  input  logic [PIXEL_W-1:0]    wdata,
  input  logic                  re,
  input  logic [COL_ADDR_W-1:0] raddr,
  output logic [PIXEL_W-1:0]    rdata
);
  logic [PIXEL_W-1:0] mem [ROW_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/row_buffer_swap.sv
// Double-buffered row store: mixer fills the back bank, display reads the front.
// Define ROWBUF_BLANK_EN to show backdrop instead of a row that was swapped in late.
module row_buffer_swap
  import ppu_pkg::*;
(
  input logic              clk,
  input logic              rst,
  row_buffer_swap_if.slave bus
);
  logic               front_sel_reg;
  logic               row_complete_reg;
  logic               row_start_reg;
  logic               late_row_reg;
  logic               rd_bank_reg;
  logic               rd_ok_reg;
  logic               row_ready;
  logic               wr_ok;
  logic               rd_ok;
  logic [PIXEL_W-1:0] bank_rdata [2];
`ifdef ROWBUF_BLANK_EN
  logic               blank_row_reg;
`endif

  // A wr_done arriving together with swap still counts the row as finished.
  assign row_ready = row_complete_reg | bus.wr_done;
  assign wr_ok     = bus.wr_en & col_valid(bus.wr_addr);
  assign rd_ok     = col_valid(bus.rd_addr);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      rowbuf_ram u_ram (
        .clk   (clk),
        .we    (wr_ok && (front_sel_reg != 1'(gi))),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .re    (rd_ok),
        .raddr (bus.rd_addr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel_reg    <= 1'b0;
      row_complete_reg <= 1'b0;
      row_start_reg    <= 1'b0;
      late_row_reg     <= 1'b0;
      rd_bank_reg      <= 1'b0;
      rd_ok_reg        <= 1'b0;
`ifdef ROWBUF_BLANK_EN
      blank_row_reg    <= 1'b0;
`endif
    end else begin
      front_sel_reg    <= front_sel_reg ^ bus.swap;
      row_start_reg    <= bus.swap;
      late_row_reg     <= bus.swap & ~row_ready;
      row_complete_reg <= bus.swap ? 1'b0 : row_ready;
      // Remember which bank was front when the read was issued.
      rd_bank_reg      <= front_sel_reg;
`ifdef ROWBUF_BLANK_EN
      rd_ok_reg        <= rd_ok & ~blank_row_reg;
      if (bus.swap) blank_row_reg <= ~row_ready;
`else
      rd_ok_reg        <= rd_ok;
`endif
    end
  end

  // Out-of-range columns, blanked rows and the reset state all read as backdrop.
  assign bus.rd_data   = rd_ok_reg ? bank_rdata[rd_bank_reg] : PIXEL_W'(BACKDROP);
  assign bus.row_start = row_start_reg;
  assign bus.late_row  = late_row_reg;
  assign bus.front_sel = front_sel_reg;
endmodule

// File: tb/tb_row_buffer_swap.sv
// Scoreboard bench for row_buffer_swap: driver pushes expected responses from a
// bank-array model, a negedge monitor pops and compares once each edge has passed.
module tb_row_buffer_swap;
  import ppu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  row_buffer_swap_if bus();

  row_buffer_swap dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         due;
    bit         chk_rd;
    logic [9:0] rd;
    logic       rs;
    logic       late;
    logic       fs;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         edge_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  // Reference model: two plain row arrays plus the row-level flags.
  logic [9:0] m_bank  [2][ROW_W];
  bit         m_known [2][ROW_W];
  bit         m_front;
  bit         m_complete;
  bit         m_blank;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_front    = 1'b0;
    m_complete = 1'b0;
    m_blank    = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < ROW_W; c++) m_known[b][c] = 1'b0;
  endtask

  task automatic set_idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_done = 1'b0;
    bus.rd_addr = 9'd320;
    bus.swap    = 1'b0;
  endtask

  // One clock of stimulus; the expected post-edge outputs go into the scoreboard.
  task automatic cycle(input bit we, input int wa, input logic [9:0] wd,
                       input bit done, input int ra, input bit sw);
    exp_t e;
    bit   finished;
    @(posedge clk); #1;
    bus.wr_en   = we;
    bus.wr_addr = 9'(wa);
    bus.wr_data = wd;
    bus.wr_done = done;
    bus.rd_addr = 9'(ra);
    bus.swap    = sw;

    finished = m_complete || done;
    e.due    = edge_cnt + 1;
    e.rs     = sw;
    e.late   = sw && !finished;
    e.fs     = m_front ^ sw;
    if (ra >= ROW_W || m_blank) begin
      e.chk_rd = 1'b1;
      e.rd     = 10'd0;
    end else begin
      e.chk_rd = m_known[m_front][ra];
      e.rd     = m_bank[m_front][ra];
    end
    q.push_back(e);

    if (we && wa < ROW_W) begin
      m_bank[!m_front][wa]  = wd;
      m_known[!m_front][wa] = 1'b1;
    end
    if (sw) begin
`ifdef ROWBUF_BLANK_EN
      m_blank = !finished;
`endif
      m_complete = 1'b0;
      m_front    = !m_front;
    end else if (done) begin
      m_complete = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_idle();
    @(negedge clk); #1;
    chk("pre_reset_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
    rst = 1'b1;
    #1;
    chk("reset_front_sel", 32'(bus.front_sel), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset_row_start", 32'(bus.row_start), 32'd0);
    chk("reset_late_row", 32'(bus.late_row), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0 && q[0].due <= edge_cnt) begin
      mon_e = q.pop_front();
      $display("[TB] edge=%0d rd_data=%h row_start=%b late_row=%b front_sel=%b",
               edge_cnt, bus.rd_data, bus.row_start, bus.late_row, bus.front_sel);
      chk("row_start", 32'(bus.row_start), 32'(mon_e.rs));
      chk("late_row", 32'(bus.late_row), 32'(mon_e.late));
      chk("front_sel", 32'(bus.front_sel), 32'(mon_e.fs));
      if (mon_e.chk_rd) chk("rd_data", 32'(bus.rd_data), 32'(mon_e.rd));
    end
  end

  initial begin
    set_idle();
    model_reset();
    do_reset();

    // Full row with data = column, then wr_done and an on-time swap.
    for (int c = 0; c < ROW_W; c++) cycle(1'b1, c, 10'(c), 1'b0, ROW_W, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b1, ROW_W, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b0, ROW_W, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 5, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b0, 319, 1'b0);

    // Late swap: partial back row, no wr_done.
    for (int c = 0; c < 8; c++) cycle(1'b1, c, 10'(100 + c), 1'b0, ROW_W, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b0, 3, 1'b1);
    for (int c = 0; c < 10; c++) cycle(1'b0, 0, 10'd0, 1'b0, c * 31, 1'b0);

    // wr_done coinciding with swap counts as complete.
    cycle(1'b0, 0, 10'd0, 1'b1, 2, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 2, 1'b0);

    // Write during the swap cycle, then two complete swaps, reading col 7 throughout.
    cycle(1'b1, 7, 10'h3FF, 1'b1, 7, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 7, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b1, 7, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b0, 7, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 7, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b1, 7, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 7, 1'b0);

    // Out-of-range write and read; back-to-back swaps.
    cycle(1'b1, 320, 10'h2AA, 1'b0, 320, 1'b0);
    cycle(1'b1, 511, 10'h155, 1'b1, 400, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b0, 64, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 64, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 0, 1'b1);
    cycle(1'b0, 0, 10'd0, 1'b0, 64, 1'b0);

    // Reset in the middle of a row while bank 1 is displayed.
    if (!m_front) cycle(1'b0, 0, 10'd0, 1'b1, ROW_W, 1'b1);
    for (int c = 0; c < 5; c++) cycle(1'b1, c, 10'(c + 50), 1'b0, c, 1'b0);
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1'b1, c, 10'(c + 60), 1'b0, c, 1'b0);
    cycle(1'b0, 0, 10'd0, 1'b1, ROW_W, 1'b1);
    for (int c = 0; c < 6; c++) cycle(1'b0, 0, 10'd0, 1'b0, c, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 339)), 10'($urandom),
            ($urandom_range(0, 49) == 0), int'($urandom_range(0, 335)),
            ($urandom_range(0, 39) == 0));

    @(posedge clk); #1;
    set_idle();
    for (int n = 0; n < 4 && q.size() > 0; n++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
